// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS hazard logic: mul/div FSM states,
// forward-select encodings and the hard-wired zero register.
package mips_pkg;

   typedef logic [1:0] md_state_t;

   localparam md_state_t MD_IDLE = 2'd0;
   localparam md_state_t MD_BUSY = 2'd1;
   localparam md_state_t MD_DONE = 2'd2;

   localparam int FWD_RF   = 0;
   localparam int REG_ZERO = 0;

   // Stage k of the bypass network is encoded as k+1; 0 means regfile.
   function automatic int fwd_stg(input int k);
      return k + 1;
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority matcher: picks the youngest downstream stage writing the
// requested register, or the regfile when none does.
module hazard_fwd_sel
   import mips_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int NSTG   = 3,
   parameter int FW     = 2
) (
   input  logic [REG_AW-1:0]      i_reg,
   input  logic [NSTG*REG_AW-1:0] i_reg_d_stg,
   input  logic [NSTG-1:0]        i_reg_wr_stg,
   output logic [FW-1:0]          o_sel
);

   logic [NSTG-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NSTG; gi++) begin : g_match
         assign hit[gi] = (i_reg != REG_AW'(REG_ZERO)) && i_reg_wr_stg[gi] &&
                          (i_reg == i_reg_d_stg[gi*REG_AW +: REG_AW]);
      end
   endgenerate

   // Scan oldest to youngest so the lowest index is the last to assign.
   always_comb begin
      o_sel = FW'(FWD_RF);
      for (int k = NSTG - 1; k >= 0; k--) begin
         if (hit[k]) o_sel = FW'(fwd_stg(k));
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside ID: operand forwarding, load-use stalls and a
// single in-flight mul/div scoreboard with stall/flush arbitration.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NSTG     = 3,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 4,
   parameter int CNT_W    = 16,
   parameter int FW       = $clog2(NSTG + 1)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [REG_AW-1:0]      i_reg_s,
   input  logic [REG_AW-1:0]      i_reg_t,
   input  logic                   i_use_s,
   input  logic                   i_use_t,
   input  logic [NSTG*REG_AW-1:0] i_reg_d_stg,
   input  logic [NSTG-1:0]        i_reg_wr_stg,
   input  logic [NSTG-1:0]        i_mem_rd_stg,
   input  logic                   i_md_start,
   input  logic [REG_AW-1:0]      i_md_dst,
   input  logic                   i_flush,
   output logic [FW-1:0]          o_fwd_a,
   output logic [FW-1:0]          o_fwd_b,
   output logic                   o_stall,
   output logic                   o_flush_id,
   output logic                   o_md_busy,
   output logic                   o_md_done,
   output logic [REG_AW-1:0]      o_md_dst,
   output logic [CNT_W-1:0]       o_stall_cnt
);

   localparam int MDC_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

   generate
      if (NSTG < 1) begin : g_bad_nstg
         $error("hazard_ctrl: NSTG must be >= 1");
      end
      if (LOAD_LAT < 1 || LOAD_LAT > NSTG) begin : g_bad_load_lat
         $error("hazard_ctrl: LOAD_LAT must be in 1..NSTG");
      end
      if (MD_LAT < 1) begin : g_bad_md_lat
         $error("hazard_ctrl: MD_LAT must be >= 1");
      end
   endgenerate

   md_state_t          state_q, state_d;
   logic [MDC_W-1:0]   cnt_q, cnt_d;
   logic [REG_AW-1:0]  md_dst_q, md_dst_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic load_use, md_active, md_struct, md_raw, md_accept;

   hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .FW(FW)) u_fwd_s (
      .i_reg        (i_reg_s),
      .i_reg_d_stg  (i_reg_d_stg),
      .i_reg_wr_stg (i_reg_wr_stg),
      .o_sel        (o_fwd_a)
   );

   hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .FW(FW)) u_fwd_t (
      .i_reg        (i_reg_t),
      .i_reg_d_stg  (i_reg_d_stg),
      .i_reg_wr_stg (i_reg_wr_stg),
      .o_sel        (o_fwd_b)
   );

   // Load data is only unforwardable while the load sits in the first LOAD_LAT stages.
   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < NSTG; k++) begin
         if (k < LOAD_LAT && i_mem_rd_stg[k]) begin
            if (i_use_s && o_fwd_a == FW'(fwd_stg(k))) load_use = 1'b1;
            if (i_use_t && o_fwd_b == FW'(fwd_stg(k))) load_use = 1'b1;
         end
      end
   end

   assign md_active = (state_q != MD_IDLE);
   assign md_struct = md_active && i_md_start;
   assign md_raw    = md_active && (md_dst_q != REG_AW'(REG_ZERO)) &&
                      ((i_use_s && i_reg_s == md_dst_q) || (i_use_t && i_reg_t == md_dst_q));

   assign o_stall    = (load_use || md_struct || md_raw) && !i_flush;
   assign o_flush_id = i_flush;
   assign md_accept  = (state_q == MD_IDLE) && i_md_start && !o_stall && !i_flush;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_dst_d = md_dst_q;
      case (state_q)
         MD_IDLE: begin
            if (md_accept) begin
               state_d  = MD_BUSY;
               cnt_d    = MDC_W'(MD_LAT - 1);
               md_dst_d = i_md_dst;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) state_d = MD_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (o_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         md_dst_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_dst_q    <= md_dst_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_md_busy   = (state_q == MD_BUSY);
   assign o_md_done   = (state_q == MD_DONE);
   assign o_md_dst    = md_dst_q;
   assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=2, CNT_W=3, MD_LAT=4, NSTG=3).
module tb_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int NSTG   = 3;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [REG_AW-1:0]      reg_s, reg_t, md_dst_in;
   logic                   use_s, use_t, md_start, flush;
   logic [NSTG*REG_AW-1:0] reg_d_stg;
   logic [NSTG-1:0]        reg_wr_stg, mem_rd_stg;
   logic [1:0]             fwd_a, fwd_b;
   logic                   stall, flush_id, md_busy, md_done;
   logic [REG_AW-1:0]      md_dst;
   logic [2:0]             stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_AW(REG_AW), .NSTG(NSTG), .LOAD_LAT(2), .MD_LAT(4), .CNT_W(3)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_reg_s      (reg_s),
      .i_reg_t      (reg_t),
      .i_use_s      (use_s),
      .i_use_t      (use_t),
      .i_reg_d_stg  (reg_d_stg),
      .i_reg_wr_stg (reg_wr_stg),
      .i_mem_rd_stg (mem_rd_stg),
      .i_md_start   (md_start),
      .i_md_dst     (md_dst_in),
      .i_flush      (flush),
      .o_fwd_a      (fwd_a),
      .o_fwd_b      (fwd_b),
      .o_stall      (stall),
      .o_flush_id   (flush_id),
      .o_md_busy    (md_busy),
      .o_md_done    (md_done),
      .o_md_dst     (md_dst),
      .o_stall_cnt  (stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      reg_s = '0; reg_t = '0; use_s = 0; use_t = 0;
      reg_d_stg = '0; reg_wr_stg = '0; mem_rd_stg = '0;
      md_start = 0; md_dst_in = '0; flush = 0;
   endtask

   task automatic pulse_reset;
      rst = 1; #1;
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      rst = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      #2;
      chk("reset_busy", 32'(md_busy), 0);
      chk("reset_done", 32'(md_done), 0);
      chk("reset_md_dst", 32'(md_dst), 0);
      chk("reset_stall_cnt", 32'(stall_cnt), 0);
      chk("reset_stall", 32'(stall), 0);
      rst = 0;
      tick();

      // Forwarding priority: {WB, MM, EX}
      reg_s = 5; reg_d_stg = {5'd0, 5'd5, 5'd5}; reg_wr_stg = 3'b011; #1;
      chk("fwd_a_ex", 32'(fwd_a), 1);
      reg_wr_stg = 3'b010; #1;
      chk("fwd_a_mm", 32'(fwd_a), 2);
      reg_s = 0; reg_d_stg = '0; reg_wr_stg = 3'b111; #1;
      chk("fwd_a_zero_reg", 32'(fwd_a), 0);
      reg_t = 11; reg_d_stg = {5'd11, 5'd0, 5'd0}; #1;
      chk("fwd_b_wb", 32'(fwd_b), 3);
      chk("fwd_no_use_stall", 32'(stall), 0);

      // Load-use with LOAD_LAT = 2
      reg_t = 7; use_t = 1; reg_d_stg = {5'd0, 5'd7, 5'd0};
      reg_wr_stg = 3'b010; mem_rd_stg = 3'b010; #1;
      chk("lu_mm_stall", 32'(stall), 1);
      chk("lu_mm_fwd_b", 32'(fwd_b), 2);
      reg_d_stg = {5'd0, 5'd0, 5'd7}; reg_wr_stg = 3'b001; mem_rd_stg = 3'b001; #1;
      chk("lu_ex_stall", 32'(stall), 1);
      reg_d_stg = {5'd7, 5'd0, 5'd0}; reg_wr_stg = 3'b100; mem_rd_stg = 3'b100; #1;
      chk("lu_wb_stall", 32'(stall), 0);
      chk("lu_wb_fwd_b", 32'(fwd_b), 3);
      reg_d_stg = {5'd0, 5'd7, 5'd0}; reg_wr_stg = 3'b010; mem_rd_stg = 3'b010; use_t = 0; #1;
      chk("lu_no_use", 32'(stall), 0);
      flush = 1; use_t = 1; #1;
      chk("lu_flush_stall", 32'(stall), 0);
      chk("lu_flush_id", 32'(flush_id), 1);
      clear_inputs();
      tick();

      // Saturating stall counter (CNT_W = 3)
      pulse_reset();
      reg_t = 7; use_t = 1; reg_d_stg = {5'd0, 5'd7, 5'd0};
      reg_wr_stg = 3'b010; mem_rd_stg = 3'b010;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), (i < 7) ? i : 7);
      end
      clear_inputs();
      tick();

      // Mul/div latency and RAW dependence on rs
      pulse_reset();
      md_start = 1; md_dst_in = 9; reg_s = 9; use_s = 1; #1;
      chk("md_issue_stall", 32'(stall), 0);
      tick();
      md_start = 0;
      for (int c = 1; c <= 6; c++) begin
         #1;
         chk($sformatf("md_busy_c%0d", c), 32'(md_busy), (c <= 4) ? 1 : 0);
         chk($sformatf("md_done_c%0d", c), 32'(md_done), (c == 5) ? 1 : 0);
         chk($sformatf("md_raw_stall_c%0d", c), 32'(stall), (c <= 5) ? 1 : 0);
         chk($sformatf("md_dst_c%0d", c), 32'(md_dst), 9);
         tick();
      end
      chk("md_stall_cnt", 32'(stall_cnt), 5);
      clear_inputs();

      // Structural hazard: second start waits for IDLE
      md_start = 1; md_dst_in = 3; #1;
      tick();
      md_dst_in = 4;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("struct_stall_c%0d", c), 32'(stall), 1);
         chk($sformatf("struct_dst_c%0d", c), 32'(md_dst), 3);
         tick();
      end
      #1;
      chk("struct_idle_stall", 32'(stall), 0);
      tick();
      chk("struct_accept_busy", 32'(md_busy), 1);
      chk("struct_accept_dst", 32'(md_dst), 4);
      flush = 1; #1;
      chk("busy_flush_stall", 32'(stall), 0);
      chk("busy_flush_id", 32'(flush_id), 1);
      md_start = 0; flush = 0;
      for (int c = 0; c < 5; c++) tick();
      chk("op2_idle_busy", 32'(md_busy), 0);
      chk("op2_idle_done", 32'(md_done), 0);
      md_start = 1; md_dst_in = 12; flush = 1; #1;
      chk("idle_flush_stall", 32'(stall), 0);
      chk("idle_flush_id", 32'(flush_id), 1);
      tick();
      chk("idle_flush_ignored", 32'(md_busy), 0);
      chk("idle_flush_dst", 32'(md_dst), 4);
      clear_inputs();
      tick();

      // Asynchronous reset in BUSY cycle 2
      md_start = 1; md_dst_in = 9; reg_s = 9; use_s = 1;
      tick();
      md_start = 0;
      tick();
      chk("ar_pre_busy", 32'(md_busy), 1);
      #2;
      rst = 1; #1;
      chk("ar_busy", 32'(md_busy), 0);
      chk("ar_stall_cnt", 32'(stall_cnt), 0);
      chk("ar_md_dst", 32'(md_dst), 0);
      rst = 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk($sformatf("ar_no_done_%0d", c), 32'(md_done), 0);
         chk($sformatf("ar_no_busy_%0d", c), 32'(md_busy), 0);
      end
      clear_inputs();
      md_start = 1; md_dst_in = 2;
      tick();
      md_start = 0;
      chk("ar_idle_accept", 32'(md_busy), 1);
      chk("ar_idle_dst", 32'(md_dst), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the MIPS core, sitting beside the ID stage. It does three jobs:
- generates forwarding selects for rs/rt across NSTG downstream stages;
- stalls on load-use with a configurable load latency;
- tracks one in-flight multi-cycle mul/div op with a scoreboard FSM, stall and flush arbitration, and a saturating stall-cycle counter.

Parameters:
REG_AW, 5, register address width
NSTG, 3, forwarding source stages; index 0 = EX (youngest), NSTG-1 = WB (oldest)
LOAD_LAT, 1, stages after EX in which load data is not yet forwardable; 1 <= LOAD_LAT <= NSTG
MD_LAT, 4, mul/div busy cycles; >= 1
CNT_W, 16, stall counter width
FW, $clog2(NSTG+1), derived width of forward selects

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_reg_s  in  REG_AW  ID rs address
i_reg_t  in  REG_AW  ID rt address
i_use_s  in  1  ID instruction actually reads rs
i_use_t  in  1  ID instruction actually reads rt
i_reg_d_stg  in  NSTG*REG_AW  dest address per stage; stage k at bits [k*REG_AW +: REG_AW]
i_reg_wr_stg  in  NSTG  register write enable per stage
i_mem_rd_stg  in  NSTG  stage k holds a load
i_md_start  in  1  ID issues a mul/div op
i_md_dst  in  REG_AW  mul/div destination register
i_flush  in  1  taken branch/jump resolved in EX; kill ID
o_fwd_a  out  FW  rs forward select; 0 = regfile, k+1 = stage k
o_fwd_b  out  FW  rt forward select, same encoding
o_stall  out  1  freeze PC/IF/ID, bubble into EX
o_flush_id  out  1  squash ID instruction
o_md_busy  out  1  mul/div in progress
o_md_done  out  1  one-cycle mul/div writeback strobe
o_md_dst  out  REG_AW  latched mul/div destination
o_stall_cnt  out  CNT_W  total stall cycles

Behaviour:
- Forwarding is combinational.
  - o_fwd_a = k+1 for the lowest k with i_reg_s != 0, i_reg_s == dest[k] and i_reg_wr_stg[k]; otherwise 0. The youngest producer wins.
  - o_fwd_b is the same function on i_reg_t.
  - Selects do not depend on i_use_*.
- Load-use hazard: raised if i_use_s is set and o_fwd_a = k+1 with i_mem_rd_stg[k] and k < LOAD_LAT. Same check on the t side with i_use_t / o_fwd_b.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - Accepted start = i_md_start & !o_stall & !i_flush, in IDLE only.
  - IDLE -> BUSY on accepted start. On the same edge: latch o_md_dst <= i_md_dst, cnt <= MD_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt == 0, next state is DONE. o_md_busy = 1 for exactly MD_LAT cycles.
  - DONE: o_md_done = 1 for one cycle, then IDLE unconditionally.
  - MD_LAT = 1: one BUSY cycle, then DONE.
- Mul/div hazards (state != IDLE):
  - structural: i_md_start;
  - RAW: (i_use_s & i_reg_s == o_md_dst) | (i_use_t & i_reg_t == o_md_dst), with o_md_dst != 0.
  - Dependence is released the cycle after DONE, because the regfile writes before it reads.
- o_stall = (load-use | md structural | md RAW) & !i_flush. Flush has priority: a squashed instruction never stalls.
- o_flush_id = i_flush (combinational). An in-flight mul/div op is older than the branch and is not cancelled.
- o_stall_cnt increments on every edge where o_stall = 1 and saturates at all-ones.
- Reset, asynchronous:
  - state IDLE, cnt 0, o_md_dst 0, o_stall_cnt 0;
  - o_md_busy = 0, o_md_done = 0.
  - Reset mid-op aborts the op; no done strobe is issued.
- Elaboration checks: NSTG >= 1, 1 <= LOAD_LAT <= NSTG, MD_LAT >= 1. Any violation is a $error.

Decomposition:
- Shared package mips_pkg:
  - FSM state typedef (md_state_t);
  - forward-select encodings FWD_RF = 0, FWD_STG(k) = k+1;
  - REG_ZERO constant.
- One sub-module, hazard_fwd_sel: the priority matcher over NSTG stages, instantiated twice (rs and rt). FSM, stall arbitration and counter stay in hazard_ctrl.

Test Plan:
- Defaults; rs = 5, EX dest 5 wr, MM dest 5 wr -> o_fwd_a = 1; with EX wr = 0 -> o_fwd_a = 2; rs = 0 with all dests 0 wr -> o_fwd_a = 0.
- LOAD_LAT = 2, rt = 7, i_use_t = 1, MM dest 7 load -> o_stall = 1; same in WB -> o_stall = 0, o_fwd_b = 3; i_use_t = 0 -> o_stall = 0.
- md start dst 9 at edge 0, MD_LAT = 4 -> o_md_busy in cycles 1-4, o_md_done in cycle 5 only, o_md_dst = 9; rs = 9, i_use_s = 1 stalls cycles 1-5 and releases in cycle 6.
- Second i_md_start during BUSY -> o_stall = 1 until IDLE, then accepted; assert with i_flush = 1 -> ignored, o_stall = 0, o_flush_id = 1.
- CNT_W = 3, continuous load-use stall for 10 cycles -> o_stall_cnt 1..7, then stays 7.
- Assert i_rst asynchronously (mid-clock) in BUSY cycle 2 -> o_md_busy, o_stall_cnt, o_md_dst are 0 before the next edge; no o_md_done follows; FSM returns to IDLE.
